// File: rtl/usb_transaction_ctrl_pkg.sv
// usb_transaction_ctrl_pkg: shared PID, handshake PID and FSM state types
package usb_transaction_ctrl_pkg;
    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_SOF   = 4'b0101,
        PID_SETUP = 4'b1101,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011
    } pid_t;
    typedef enum logic [3:0] {
        HS_ACK   = 4'b0010,
        HS_NAK   = 4'b1010,
        HS_STALL = 4'b1110
    } hs_pid_t;
    typedef enum logic [1:0] {S_IDLE, S_WAIT_DATA, S_TURNAROUND, S_SEND} state_t;
    function automatic logic [7:0] hs_byte(input hs_pid_t p);
        return {~p, p};
    endfunction
endpackage

// File: rtl/usb_transaction_ctrl.sv
// usb_transaction_ctrl: device-side token/data/handshake sequencing with per-endpoint data toggles
module usb_transaction_ctrl
    import usb_transaction_ctrl_pkg::*;
#(
    parameter int TA_CYCLES    = 4,
    parameter int DATA_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        usb_reset,
    input  logic [6:0]  device_addr,
    input  logic        token_valid,
    input  logic [3:0]  token_pid,
    input  logic [6:0]  token_addr,
    input  logic [3:0]  token_endp,
    input  logic        data_done,
    input  logic [3:0]  data_pid,
    input  logic        data_crc_ok,
    input  logic [15:0] ep_ready,
    input  logic [15:0] ep_stall,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic [3:0]  ep_endp,
    output logic        ep_setup,
    output logic        ep_commit,
    output logic        ep_discard,
    output logic [15:0] toggle,
    output logic        busy
);
    localparam int CW = $clog2((DATA_TIMEOUT > TA_CYCLES ? DATA_TIMEOUT : TA_CYCLES) + 1);
    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    hs_pid_t         r_hs;
    logic            w_tok;
    logic            w_commit;
    hs_pid_t         w_hs;
    assign w_tok = token_valid && token_addr == device_addr &&
                   (token_pid == PID_OUT || token_pid == PID_SETUP || token_pid == PID_IN);
    assign w_hs = ep_setup ? HS_ACK : ep_stall[ep_endp] ? HS_STALL : !ep_ready[ep_endp] ? HS_NAK : HS_ACK;
    assign w_commit = ep_setup || (!ep_stall[ep_endp] && ep_ready[ep_endp] &&
                      data_pid == (toggle[ep_endp] ? PID_DATA1 : PID_DATA0));
    assign busy = r_state != S_IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_hs       <= HS_NAK;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            ep_endp    <= 4'd0;
            ep_setup   <= 1'b0;
            ep_commit  <= 1'b0;
            ep_discard <= 1'b0;
            toggle     <= 16'h0000;
        end else begin
            ep_commit  <= 1'b0;
            ep_discard <= 1'b0;
            if (usb_reset) begin
                r_state  <= S_IDLE;
                tx_valid <= 1'b0;
                toggle   <= 16'h0000;
            end else if (w_tok && r_state != S_SEND) begin
                // a fresh token also silently abandons any transaction still in flight
                ep_endp  <= token_endp;
                ep_setup <= token_pid == PID_SETUP;
                if (token_pid == PID_IN) begin
                    r_hs    <= ep_stall[token_endp] ? HS_STALL : HS_NAK;
                    r_cnt   <= CW'(TA_CYCLES - 1);
                    r_state <= S_TURNAROUND;
                end else begin
                    r_cnt   <= CW'(DATA_TIMEOUT);
                    r_state <= S_WAIT_DATA;
                end
            end else begin
                case (r_state)
                    S_WAIT_DATA: begin
                        if (data_done && !data_crc_ok) begin
                            ep_discard <= 1'b1;
                            r_state    <= S_IDLE;
                        end else if (data_done) begin
                            r_hs       <= w_hs;
                            ep_commit  <= w_commit;
                            ep_discard <= !w_commit;
                            r_cnt      <= CW'(TA_CYCLES - 1);
                            r_state    <= S_TURNAROUND;
                            if (w_commit) toggle[ep_endp] <= ep_setup | ~toggle[ep_endp];
                        end else if (r_cnt == '0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_TURNAROUND: begin
                        if (r_cnt == '0) begin
                            tx_data  <= hs_byte(r_hs);
                            tx_valid <= 1'b1;
                            r_state  <= S_SEND;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_SEND: begin
                        if (tx_ready) begin
                            tx_valid <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_usb_transaction_ctrl.sv
// tb_usb_transaction_ctrl: directed and randomized transactions checked against a behavioural model
module tb_usb_transaction_ctrl;
    localparam int TA = 4;
    localparam int TO = 64;
    logic        clk = 1'b0;
    logic        rst, usb_reset;
    logic [6:0]  device_addr;
    logic        token_valid;
    logic [3:0]  token_pid;
    logic [6:0]  token_addr;
    logic [3:0]  token_endp;
    logic        data_done;
    logic [3:0]  data_pid;
    logic        data_crc_ok;
    logic [15:0] ep_ready, ep_stall;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [3:0]  ep_endp;
    logic        ep_setup, ep_commit, ep_discard;
    logic [15:0] toggle;
    logic        busy;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_tog;

    usb_transaction_ctrl #(.TA_CYCLES(TA), .DATA_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .usb_reset(usb_reset), .device_addr(device_addr),
        .token_valid(token_valid), .token_pid(token_pid), .token_addr(token_addr),
        .token_endp(token_endp), .data_done(data_done), .data_pid(data_pid),
        .data_crc_ok(data_crc_ok), .ep_ready(ep_ready), .ep_stall(ep_stall),
        .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .ep_endp(ep_endp),
        .ep_setup(ep_setup), .ep_commit(ep_commit), .ep_discard(ep_discard),
        .toggle(toggle), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_token(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp);
        token_valid = 1'b1;
        token_pid   = pid;
        token_addr  = addr;
        token_endp  = endp;
        step();
        token_valid = 1'b0;
    endtask

    task automatic handshake(input logic [7:0] exp_b, input int hold);
        for (int i = 1; i < TA; i++) begin
            step();
            chk("ta_quiet", 32'(tx_valid), 0);
            chk("ta_no_strobe", 32'({ep_commit, ep_discard}), 0);
        end
        step();
        chk("hs_valid", 32'(tx_valid), 1);
        chk("hs_byte", 32'(tx_data), 32'(exp_b));
        tx_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hs_hold_valid", 32'(tx_valid), 1);
            chk("hs_hold_byte", 32'(tx_data), 32'(exp_b));
        end
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk("hs_done_valid", 32'(tx_valid), 0);
        chk("hs_done_busy", 32'(busy), 0);
    endtask

    task automatic out_xact(input logic [3:0] tpid, input logic [3:0] endp, input logic [3:0] dpid,
                            input logic crc, input logic rdy, input logic stl, input int gap, input int hold);
        logic       setup;
        logic       has_hs, exp_c, exp_d;
        logic [7:0] exp_hs;
        setup  = tpid == 4'b1101;
        exp_hs = 8'h00;
        has_hs = 1'b1;
        exp_c  = 1'b0;
        exp_d  = 1'b1;
        if (!crc) has_hs = 1'b0;
        else if (setup) begin exp_hs = 8'hD2; exp_c = 1'b1; exp_d = 1'b0; m_tog[endp] = 1'b1; end
        else if (stl) exp_hs = 8'h1E;
        else if (!rdy) exp_hs = 8'h5A;
        else if (dpid == (m_tog[endp] ? 4'b1011 : 4'b0011)) begin
            exp_hs = 8'hD2; exp_c = 1'b1; exp_d = 1'b0; m_tog[endp] = ~m_tog[endp];
        end else exp_hs = 8'hD2;
        send_token(tpid, device_addr, endp);
        chk("tok_busy", 32'(busy), 1);
        chk("tok_endp", 32'(ep_endp), 32'(endp));
        chk("tok_setup", 32'(ep_setup), 32'(setup));
        repeat (gap) step();
        ep_ready       = 16'($urandom);
        ep_ready[endp] = rdy;
        ep_stall       = 16'($urandom);
        ep_stall[endp] = stl;
        data_pid       = dpid;
        data_crc_ok    = crc;
        data_done      = 1'b1;
        step();
        data_done = 1'b0;
        chk("commit", 32'(ep_commit), 32'(exp_c));
        chk("discard", 32'(ep_discard), 32'(exp_d));
        chk("toggle", 32'(toggle), 32'(m_tog));
        if (has_hs) handshake(exp_hs, hold);
        else begin
            step();
            chk("nohs_strobes", 32'({ep_commit, ep_discard}), 0);
            chk("nohs_busy", 32'(busy), 0);
            repeat (TA + 2) step();
            chk("nohs_valid", 32'(tx_valid), 0);
        end
    endtask

    task automatic in_xact(input logic [3:0] endp, input logic stl, input int hold);
        ep_stall       = 16'($urandom);
        ep_stall[endp] = stl;
        send_token(4'b1001, device_addr, endp);
        chk("in_busy", 32'(busy), 1);
        handshake(stl ? 8'h1E : 8'h5A, hold);
        chk("in_toggle", 32'(toggle), 32'(m_tog));
    endtask

    initial begin
        logic seen;
        logic [3:0] e;
        rst = 1'b1; usb_reset = 1'b0; device_addr = 7'd5;
        token_valid = 1'b1; token_pid = 4'b0001; token_addr = 7'd5; token_endp = 4'd3;
        data_done = 1'b1; data_pid = 4'b0011; data_crc_ok = 1'b1;
        ep_ready = 16'hFFFF; ep_stall = 16'h0000; tx_ready = 1'b0;
        m_tog = 16'h0000;
        step();
        step();
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_ep_endp", 32'(ep_endp), 0);
        chk("rst_ep_setup", 32'(ep_setup), 0);
        chk("rst_commit", 32'(ep_commit), 0);
        chk("rst_discard", 32'(ep_discard), 0);
        chk("rst_toggle", 32'(toggle), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0; token_valid = 1'b0; data_done = 1'b0;
        step();
        out_xact(4'b0001, 4'd2, 4'b0011, 1'b1, 1'b1, 1'b0, 3, 0);
        out_xact(4'b0001, 4'd2, 4'b0011, 1'b1, 1'b1, 1'b0, 2, 1);
        out_xact(4'b0001, 4'd2, 4'b1011, 1'b1, 1'b0, 1'b0, 1, 0);
        out_xact(4'b0001, 4'd2, 4'b1011, 1'b1, 1'b1, 1'b1, 1, 0);
        out_xact(4'b1101, 4'd0, 4'b0011, 1'b0, 1'b1, 1'b0, 2, 0);
        out_xact(4'b1101, 4'd7, 4'b0011, 1'b1, 1'b0, 1'b1, 0, 0);
        send_token(4'b0001, device_addr, 4'd1);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            seen = seen | ep_commit | ep_discard | tx_valid;
        end
        chk("to_still_busy", 32'(busy), 1);
        for (int i = 0; i < 10; i++) begin
            step();
            seen = seen | ep_commit | ep_discard | tx_valid;
        end
        chk("to_idle", 32'(busy), 0);
        chk("to_no_strobe", 32'(seen), 0);
        send_token(4'b0001, 7'd6, 4'd1);
        chk("addr_miss_busy", 32'(busy), 0);
        data_done = 1'b1; data_crc_ok = 1'b1;
        step();
        data_done = 1'b0;
        step();
        chk("idle_data_ignored", 32'({ep_commit, ep_discard, busy}), 0);
        out_xact(4'b0001, 4'd3, 4'b0011, 1'b1, 1'b1, 1'b0, TO - 1, 0);
        send_token(4'b0001, device_addr, 4'd4);
        step();
        in_xact(4'd4, 1'b0, 2);
        out_xact(4'b0001, 4'd5, 4'b0011, 1'b1, 1'b1, 1'b0, 1, 10);
        for (int n = 0; n < 40; n++) begin
            device_addr = 7'($urandom);
            e = 4'($urandom);
            if ($urandom_range(2) == 0) in_xact(e, $urandom_range(3) == 0, $urandom_range(3));
            else out_xact($urandom_range(1) ? 4'b0001 : 4'b1101, e,
                          $urandom_range(1) ? 4'b1011 : 4'b0011, $urandom_range(4) != 0,
                          $urandom_range(3) != 0, $urandom_range(5) == 0,
                          $urandom_range(8), $urandom_range(3));
        end
        out_xact(4'b1101, 4'd9, 4'b0011, 1'b1, 1'b1, 1'b0, 0, 0);
        chk("pre_busrst_toggle", 32'(toggle[9]), 1);
        ep_stall = 16'h0000;
        send_token(4'b1001, device_addr, 4'd6);
        repeat (TA) step();
        chk("send_reached", 32'(tx_valid), 1);
        repeat (3) step();
        usb_reset = 1'b1;
        step();
        usb_reset = 1'b0;
        m_tog = 16'h0000;
        chk("busrst_valid", 32'(tx_valid), 0);
        chk("busrst_toggle", 32'(toggle), 32'(m_tog));
        chk("busrst_busy", 32'(busy), 0);
        out_xact(4'b0001, 4'd8, 4'b0011, 1'b1, 1'b1, 1'b0, 2, 0);
        send_token(4'b1001, device_addr, 4'd8);
        repeat (TA) step();
        chk("send_reached2", 32'(tx_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_valid", 32'(tx_valid), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_toggle", 32'(toggle), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
